// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Result is computed from latched operands and committed after a fixed latency.
module mdu_multicycle #(
    parameter int W       = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cancel,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         done
);

    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;

    logic            is_sgn, is_div, acc_add, acc_sub;
    logic            a_neg, b_neg;
    logic [W-1:0]    mag_a, mag_b, div_b, uq, ur, q, r;
    logic [2*W-1:0]  ext_a, ext_b, prod, acc, res;

    always_comb begin
        is_sgn  = 1'b0;
        is_div  = 1'b0;
        acc_add = 1'b0;
        acc_sub = 1'b0;
        unique case (op_q)
            3'd0: is_sgn = 1'b1;
            3'd1: begin is_sgn = 1'b1; is_div = 1'b1; end
            3'd2: ;
            3'd3: is_div = 1'b1;
            3'd4: begin is_sgn = 1'b1; acc_add = 1'b1; end
            3'd5: acc_add = 1'b1;
            3'd6: begin is_sgn = 1'b1; acc_sub = 1'b1; end
            3'd7: acc_sub = 1'b1;
            default: ;
        endcase
    end

    // Sign/zero-extended 2W product is exact modulo 2^(2W) for both signednesses.
    assign ext_a = {{W{is_sgn & a_q[W-1]}}, a_q};
    assign ext_b = {{W{is_sgn & b_q[W-1]}}, b_q};
    assign prod  = ext_a * ext_b;
    assign acc   = {hi_q, lo_q};

    // Magnitude divide then sign fix; -2^(W-1)/-1 naturally wraps to LO=A, HI=0.
    assign a_neg = is_sgn & a_q[W-1];
    assign b_neg = is_sgn & b_q[W-1];
    assign mag_a = a_neg ? -a_q : a_q;
    assign mag_b = b_neg ? -b_q : b_q;
    assign div_b = (mag_b == '0) ? W'(1) : mag_b;
    assign uq    = mag_a / div_b;
    assign ur    = mag_a % div_b;
    assign q     = (a_neg ^ b_neg) ? -uq : uq;
    assign r     = a_neg ? -ur : ur;

    always_comb begin
        res = prod;
        if (is_div) begin
            if (b_q == '0) res = {a_q, {W{1'b1}}};
            else           res = {r, q};
        end else if (acc_add) begin
            res = acc + prod;
        end else if (acc_sub) begin
            res = acc - prod;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = (op == 3'd1 || op == 3'd3) ? CW'(DIV_LAT - 1)
                                                         : CW'(MUL_LAT - 1);
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                    hi_d    = res[2*W-1:W];
                    lo_d    = res[W-1:0];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
    assign busy = (state_q == RUN) | start;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Scoreboard bench for mdu_multicycle: random and directed ops
// checked against a plain-arithmetic HI/LO model.
module tb_mdu_multicycle;

    localparam int W       = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic          clk, rst_n, start, cancel, hi_we, lo_we;
    logic [2:0]    op;
    logic [W-1:0]  a, b, wdata, hi, lo;
    logic          busy, done;

    mdu_multicycle #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int seen = 0;
    int exp_done = 0;
    logic [63:0] sb[$];
    logic [63:0] mon_e;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endfunction

    function automatic logic [63:0] model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        longint sx, sy, ux, uy, acc, qq, rr;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'(x);
        uy  = longint'(y);
        acc = longint'({mhi, mlo});
        case (o)
            3'd0: return sx * sy;
            3'd2: return ux * uy;
            3'd4: return acc + sx * sy;
            3'd5: return acc + ux * uy;
            3'd6: return acc - sx * sy;
            3'd7: return acc - ux * uy;
            3'd1: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                qq = sx / sy;
                rr = sx % sy;
                return {rr[31:0], qq[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                qq = ux / uy;
                rr = ux % uy;
                return {rr[31:0], qq[31:0]};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            seen++;
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'(seen), 64'(exp_done));
            end else begin
                mon_e = sb.pop_front();
                chk("sb_hi", 64'(hi), 64'(mon_e[63:32]));
                chk("sb_lo", 64'(lo), 64'(mon_e[31:0]));
            end
        end
    end

    // mode: 0 normal, 1 cancel at busy-cycle 'at', 2 reset at 'at', 3 poke start/MT* mid-run
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int mode, input int at);
        logic [63:0] e;
        int n, lat;
        lat = (o == 3'd1 || o == 3'd3) ? DIV_LAT : MUL_LAT;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        if (mode == 0 || mode == 3) begin
            e = model(o, x, y);
            sb.push_back(e);
            {mhi, mlo} = e;
            exp_done++;
        end
        n = 0;
        while (busy && n < 64) begin
            n++;
            if (mode == 1 && n == at) cancel = 1'b1;
            if (mode == 3 && n == 2) begin
                start = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
            end
            if (mode == 2 && n == at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_hi", 64'(hi), 64'(0));
                chk("rst_lo", 64'(lo), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                mhi = '0; mlo = '0;
                #1 rst_n = 1'b1;
                break;
            end
            @(negedge clk);
            cancel = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        end
        if (mode == 2) @(negedge clk);
        chk("busy_timeout", 64'(n < 64), 64'(1));
        if (mode == 0 || mode == 3) chk("latency", 64'(n), 64'(lat));
        if (mode == 1) chk("cancel_busy", 64'(n), 64'(at));
        if (mode == 1 || mode == 2) begin
            chk("keep_hi", 64'(hi), 64'(mhi));
            chk("keep_lo", 64'(lo), 64'(mlo));
        end
        chk("done_count", 64'(seen), 64'(exp_done));
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        hi_we = hw; lo_we = lw; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) mhi = d;
        if (lw) mlo = d;
        chk("mt_hi", 64'(hi), 64'(mhi));
        chk("mt_lo", 64'(lo), 64'(mlo));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] ro;
        logic [31:0] rx, ry;
        clk = 0; rst_n = 0; start = 0; cancel = 0; hi_we = 0; lo_we = 0;
        op = '0; a = '0; b = '0; wdata = '0;
        #12;
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
        chk("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);
        run_op(3'd1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd0, 0, 0);
        chk("divz_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
        chk("divz_hi", 64'(hi), 64'd7);
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("divov_lo", 64'(lo), 64'h0000_0000_8000_0000);
        chk("divov_hi", 64'(hi), 64'd0);
        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd1, 32'd1, 0, 0);
        chk("madd_hi", 64'(hi), 64'd1);
        chk("madd_lo", 64'(lo), 64'd0);
        mt(1'b1, 1'b1, 32'h1234_5678);

        run_op(3'd1, 32'd100, 32'd7, 1, 4);
        run_op(3'd0, 32'd5, 32'd6, 1, MUL_LAT);
        run_op(3'd2, 32'hDEAD_BEEF, 32'd3, 3, 0);
        run_op(3'd3, 32'd1000, 32'd9, 3, 0);
        run_op(3'd1, 32'd50, 32'd2, 2, 3);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) rx = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) ry = 32'hFFFF_FFFF;
            if ($urandom_range(0, 9) == 0) mt(1'b1, 1'($urandom), $urandom);
            run_op(ro, rx, ry, ($urandom_range(0, 9) == 0) ? 1 : 0,
                   $urandom_range(1, MUL_LAT));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
